// File: rtl/spi_target_if.sv
// Bus bundle for spi_target: SPI pins plus the CPU-side rx/tx byte handshake.
// The target uses the slave view; a master model or the SoC glue uses the master view.
interface spi_target_if;
  logic       SPI_CLK;
  logic       SPI_MOSI;
  logic       SPI_CS;
  logic       SPI_MISO;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_underrun;
  logic       busy;

  modport slave (
    input  SPI_CLK, SPI_MOSI, SPI_CS, tx_data, tx_wr,
    output SPI_MISO, miso_oe, rx_data, rx_valid, tx_full, tx_underrun, busy
  );

  modport master (
    output SPI_CLK, SPI_MOSI, SPI_CS, tx_data, tx_wr,
    input  SPI_MISO, miso_oe, rx_data, rx_valid, tx_full, tx_underrun, busy
  );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled by CLK: MSB-first 8-bit frames, byte deserialiser
// on MOSI and a one-byte transmit holding register feeding MISO.
module spi_target (
  input  logic          CLK,
  input  logic          resetn,
  spi_target_if.slave   bus
);

  // Pin synchronisers; the _d stage on SCK and CS exists only for edge detection.
  logic sck_meta_q, sck_s_q, sck_d_q;
  logic cs_meta_q, cs_s_q, cs_d_q;
  logic mosi_meta_q, mosi_s_q;

  // NOTE: idle values here (SCK low, CS high) keep reset release from looking like a select or an SCK edge.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_d_q     <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      cs_d_q      <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      sck_meta_q  <= bus.SPI_CLK;
      sck_s_q     <= sck_meta_q;
      sck_d_q     <= sck_s_q;
      cs_meta_q   <= bus.SPI_CS;
      cs_s_q      <= cs_meta_q;
      cs_d_q      <= cs_s_q;
      mosi_meta_q <= bus.SPI_MOSI;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  logic sck_rise, sck_fall, sel, selected;
  assign sck_rise = sck_s_q & ~sck_d_q;
  assign sck_fall = ~sck_s_q & sck_d_q;
  assign sel      = cs_d_q & ~cs_s_q;
  assign selected = ~cs_s_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;
  logic       underrun_q, underrun_d;

  logic load, write_hold;
  // A load happens at select and on the SCK fall that closes each byte.
  assign load = sel | (selected & sck_fall & (bit_cnt_q == 3'd0));
  // With a load in the same cycle, the holding register only accepts a write if it was full.
  assign write_hold = bus.tx_wr & (tx_full_q ? load : ~load);

  // NOTE: next-state logic uses blocking assignments after a full set of defaults, so no latches form.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    tx_full_d  = tx_full_q;
    underrun_d = 1'b0;

    if (!selected) begin
      bit_cnt_d = 3'd0;
    end else if (sel) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s_q};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = {rx_shift_q[6:0], mosi_s_q};
        rx_valid_d = 1'b1;
      end
    end

    if (load) begin
      if (tx_full_q) begin
        tx_shift_d = hold_q;
        tx_full_d  = 1'b0;
      end else if (bus.tx_wr) begin
        tx_shift_d = bus.tx_data;
      end else begin
        tx_shift_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end else if (selected && sck_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end

    if (write_hold) begin
      hold_d    = bus.tx_data;
      tx_full_d = 1'b1;
    end
  end

  // NOTE: sequential state updates use non-blocking assignments only.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_shift_q <= 8'hFF;
      hold_q     <= 8'h00;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.SPI_MISO    = selected ? tx_shift_q[7] : 1'b1;
  assign bus.miso_oe     = selected;
  assign bus.busy        = selected;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_full     = tx_full_q;
  assign bus.tx_underrun = underrun_q;

endmodule
